dms_chan_store: RTL and testbench

Per-channel state store for the adaptation-speed short-term and long-term averages (DMS, DML) in the multi-channel ADPCM datapath. The FILTA/FILTB stage writes its updated values DMSP/DMLP into the store. On the next frame the store reads those values back as DMS/DML for the same channel, so it closes the z^-1 loop around the filters for up to NCH channels. After reset it sequences a clear of every channel before accepting traffic.

---
 rtl/adpcm_pkg.sv | 27 ++
 rtl/dms_chan_ram.sv | 28 ++
 rtl/dms_chan_store.sv | 154 +++++++++++++++
 tb/tb_dms_chan_store.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/adpcm_pkg.sv
// Shared widths and the packed per-channel adaptation-speed state word.
// DMS/DML are carried together as {dml, dms} through the channel store.
package adpcm_pkg;

    localparam int DMS_W = 12;
    localparam int DML_W = 14;
    localparam int ST_W  = DMS_W + DML_W;

    typedef struct packed {
        logic [DML_W-1:0] dml;
        logic [DMS_W-1:0] dms;
    } dms_state_t;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } store_state_t;

    function automatic dms_state_t pack_state(input logic [DMS_W-1:0] dms,
                                              input logic [DML_W-1:0] dml);
        dms_state_t s;
        s.dms = dms;
        s.dml = dml;
        return s;
    endfunction

endpackage

// File: rtl/dms_chan_ram.sv
// NCH-deep state array: one synchronous write port, one combinational read port.
// Contents are deliberately not reset; the owner sweeps it clear after reset.
module dms_chan_ram
    import adpcm_pkg::*;
#(
    parameter int NCH = 32,
    parameter int CHW = 5
)
(
    input  logic            clk,
    input  logic            i_wr_en,
    input  logic [CHW-1:0]  i_wr_addr,
    input  logic [ST_W-1:0] i_wr_data,
    input  logic [CHW-1:0]  i_rd_addr,
    output logic [ST_W-1:0] o_rd_data
);

    logic [ST_W-1:0] r_mem [NCH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/dms_chan_store.sv
// Per-channel DMS/DML store closing the z^-1 loop around FILTA/FILTB.
// Sweeps every channel to zero after reset, then serves reads/writes/clears.
module dms_chan_store
    import adpcm_pkg::*;
#(
    parameter int NCH = 32,
    parameter int CHW = 5
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_req,
    input  logic [CHW-1:0]   rd_ch,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [DMS_W-1:0] rd_dms,
    output logic [DML_W-1:0] rd_dml,
    input  logic             wr_valid,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [DMS_W-1:0] wr_dmsp,
    input  logic [DML_W-1:0] wr_dmlp,
    output logic             wr_ready,
    input  logic             clr_req,
    input  logic [CHW-1:0]   clr_ch,
    output logic             busy
);

    store_state_t    r_state;
    store_state_t    w_state_next;
    logic [CHW-1:0]  r_sweep_cnt;
    logic            w_run;
    logic            w_busy;

    logic            w_clr_acc;
    logic            w_wr_acc;
    logic            w_rd_acc;

    logic            w_ram_we;
    logic [CHW-1:0]  w_ram_waddr;
    logic [ST_W-1:0] w_ram_wdata;
    logic [ST_W-1:0] w_ram_rdata;

    logic [NCH-1:0]  r_live;
    logic [NCH-1:0]  w_live_clr;
    logic [NCH-1:0]  w_live_set;

    dms_state_t      w_new_word;
    dms_state_t      w_rd_word;
    dms_state_t      r_rd_data;
    logic            r_rd_valid;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            ST_INIT: begin
                if (r_sweep_cnt == CHW'(NCH - 1)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_run  = 1'b1;
                w_busy = 1'b0;
            end
            default: w_state_next = ST_INIT;
        endcase
    end

    assign rd_ready = w_run;
    assign wr_ready = w_run;
    assign busy     = w_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sweep_cnt <= '0;
        end else if (r_state == ST_INIT) begin
            r_sweep_cnt <= r_sweep_cnt + CHW'(1);
        end
    end

    // ---------------- write / clear arbitration ----------------
    // A clear never touches the array: it drops the channel's live flag,
    // so a clear and a write to different channels share one write port.
    assign w_new_word = pack_state(wr_dmsp, wr_dmlp);
    assign w_clr_acc  = w_run && clr_req;
    assign w_wr_acc   = w_run && wr_valid && !(clr_req && (clr_ch == wr_ch));
    assign w_rd_acc   = w_run && rd_req;

    assign w_ram_we    = !w_run || w_wr_acc;
    assign w_ram_waddr = w_run ? wr_ch : r_sweep_cnt;
    assign w_ram_wdata = w_run ? w_new_word : '0;

    dms_chan_ram #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_ram_we),
        .i_wr_addr (w_ram_waddr),
        .i_wr_data (w_ram_wdata),
        .i_rd_addr (rd_ch),
        .o_rd_data (w_ram_rdata)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_live
            assign w_live_clr[gi] = w_run ? (w_clr_acc && (clr_ch == CHW'(gi)))
                                          : (r_sweep_cnt == CHW'(gi));
            assign w_live_set[gi] = w_wr_acc && (wr_ch == CHW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        r_live <= (r_live & ~w_live_clr) | w_live_set;
    end

    // ---------------- read path with write-first forwarding ----------------
    always_comb begin
        w_rd_word = r_live[rd_ch] ? dms_state_t'(w_ram_rdata) : '0;
        if (clr_req && (clr_ch == rd_ch)) begin
            w_rd_word = '0;
        end else if (wr_valid && (wr_ch == rd_ch)) begin
            w_rd_word = w_new_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_dms   = r_rd_data.dms;
    assign rd_dml   = r_rd_data.dml;

endmodule

// File: tb/tb_dms_chan_store.sv
// Directed + short random checks of dms_chan_store against a per-channel model,
// with expected read words queued at issue and popped when rd_valid returns.
module tb_dms_chan_store;

    logic        clk;
    logic        reset;
    logic        rd_req;
    logic [4:0]  rd_ch;
    logic        rd_ready;
    logic        rd_valid;
    logic [11:0] rd_dms;
    logic [13:0] rd_dml;
    logic        wr_valid;
    logic [4:0]  wr_ch;
    logic [11:0] wr_dmsp;
    logic [13:0] wr_dmlp;
    logic        wr_ready;
    logic        clr_req;
    logic [4:0]  clr_ch;
    logic        busy;

    int          n_assert;
    int          n_fail;
    logic [25:0] sb[$];
    logic [11:0] m_dms [32];
    logic [13:0] m_dml [32];
    bit          in_run;

    dms_chan_store #(.NCH(32), .CHW(5)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_req   (rd_req),
        .rd_ch    (rd_ch),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_dms   (rd_dms),
        .rd_dml   (rd_dml),
        .wr_valid (wr_valid),
        .wr_ch    (wr_ch),
        .wr_dmsp  (wr_dmsp),
        .wr_dmlp  (wr_dmlp),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .clr_ch   (clr_ch),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and check the read port against the scoreboard.
    task automatic step();
        logic [25:0] e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rd_valid", 32'(rd_valid), 32'(1'b1));
            check("rd_dms", 32'(rd_dms), 32'(e[11:0]));
            check("rd_dml", 32'(rd_dml), 32'(e[25:12]));
        end else begin
            check("rd_valid_idle", 32'(rd_valid), 32'(1'b0));
        end
    endtask

    task automatic idle_inputs();
        rd_req   = 1'b0;
        rd_ch    = '0;
        wr_valid = 1'b0;
        wr_ch    = '0;
        wr_dmsp  = '0;
        wr_dmlp  = '0;
        clr_req  = 1'b0;
        clr_ch   = '0;
    endtask

    task automatic model_zero();
        for (int c = 0; c < 32; c++) begin
            m_dms[c] = '0;
            m_dml[c] = '0;
        end
    endtask

    task automatic xact(input logic rd, input logic [4:0] rch,
                        input logic wr, input logic [4:0] wch,
                        input logic [11:0] dms, input logic [13:0] dml,
                        input logic clr, input logic [4:0] cch);
        logic [25:0] e;
        rd_req   = rd;
        rd_ch    = rch;
        wr_valid = wr;
        wr_ch    = wch;
        wr_dmsp  = dms;
        wr_dmlp  = dml;
        clr_req  = clr;
        clr_ch   = cch;
        if (in_run) begin
            if (rd) begin
                if (clr && cch == rch)     e = '0;
                else if (wr && wch == rch) e = {dml, dms};
                else                       e = {m_dml[rch], m_dms[rch]};
                sb.push_back(e);
            end
            if (wr) begin
                m_dms[wch] = dms;
                m_dml[wch] = dml;
            end
            if (clr) begin
                m_dms[cch] = '0;
                m_dml[cch] = '0;
            end
        end
        step();
        idle_inputs();
    endtask

    task automatic rd(input logic [4:0] c);
        xact(1'b1, c, 1'b0, 5'd0, 12'h0, 14'h0, 1'b0, 5'd0);
    endtask

    task automatic wr(input logic [4:0] c, input logic [11:0] dms, input logic [13:0] dml);
        xact(1'b0, 5'd0, 1'b1, c, dms, dml, 1'b0, 5'd0);
    endtask

    // Release reset and walk the 32-cycle sweep; traffic on cycle 0 must be ignored.
    task automatic run_init();
        in_run = 1'b0;
        model_zero();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("init_busy", 32'(busy), 32'(1'b1));
            check("init_rd_ready", 32'(rd_ready), 32'(1'b0));
            check("init_wr_ready", 32'(wr_ready), 32'(1'b0));
            if (i == 0) xact(1'b1, 5'd2, 1'b1, 5'd2, 12'h555, 14'h1555, 1'b0, 5'd0);
            else        step();
        end
        check("run_busy", 32'(busy), 32'(1'b0));
        check("run_rd_ready", 32'(rd_ready), 32'(1'b1));
        check("run_wr_ready", 32'(wr_ready), 32'(1'b1));
        in_run = 1'b1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        in_run   = 1'b0;
        reset    = 1'b1;
        idle_inputs();
        model_zero();
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
        check("rst_rd_dms", 32'(rd_dms), 32'(12'h0));
        check("rst_rd_dml", 32'(rd_dml), 32'(14'h0));
        check("rst_busy", 32'(busy), 32'(1'b1));
        check("rst_rd_ready", 32'(rd_ready), 32'(1'b0));
        check("rst_wr_ready", 32'(wr_ready), 32'(1'b0));

        run_init();
        for (int c = 0; c < 32; c++) rd(5'(c));

        wr(5'd5, 12'hA5C, 14'h2F01);
        rd(5'd5);

        xact(1'b1, 5'd7, 1'b1, 5'd7, 12'h123, 14'h0ABC, 1'b0, 5'd0);
        wr(5'd8, 12'h777, 14'h1234);
        xact(1'b1, 5'd8, 1'b1, 5'd7, 12'h321, 14'h0321, 1'b0, 5'd0);
        rd(5'd7);

        xact(1'b0, 5'd0, 1'b1, 5'd3, 12'hFFF, 14'h3FFF, 1'b1, 5'd3);
        rd(5'd3);
        xact(1'b0, 5'd0, 1'b1, 5'd4, 12'hFFF, 14'h3FFF, 1'b1, 5'd3);
        rd(5'd3);
        rd(5'd4);

        wr(5'd10, 12'hABC, 14'h2222);
        xact(1'b1, 5'd10, 1'b0, 5'd0, 12'h0, 14'h0, 1'b1, 5'd10);
        wr(5'd11, 12'h0F0, 14'h0F0F);
        xact(1'b1, 5'd11, 1'b1, 5'd11, 12'h111, 14'h1111, 1'b1, 5'd11);
        rd(5'd10);
        rd(5'd11);
        rd(5'd2);

        for (int i = 0; i < 60; i++) begin
            xact(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 12'($urandom), 14'($urandom),
                 1'($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
        end
        for (int c = 0; c < 8; c++) rd(5'(c));

        wr(5'd9, 12'h0AA, 14'h0155);
        rd_req = 1'b1;
        rd_ch  = 5'd9;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        check("pre_rst_rd_valid", 32'(rd_valid), 32'(1'b1));
        reset = 1'b1;
        #1;
        check("async_rst_rd_valid", 32'(rd_valid), 32'(1'b0));
        check("async_rst_busy", 32'(busy), 32'(1'b1));
        check("async_rst_rd_ready", 32'(rd_ready), 32'(1'b0));
        sb.delete();
        in_run = 1'b0;
        step();
        step();
        run_init();
        rd(5'd9);
        rd(5'd5);
        rd(5'd2);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
